// File: rtl/fp_alu_pipe.sv
// fp_alu_pipe: pipelined IEEE-style add/sub/mul with valid/ready flow control.
// Operands are captured on accept, then S1 classifies/aligns/multiplies,
// S2 adds and normalises, S3 saturates/flushes and packs the output registers.
module fp_alu_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [1:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             overflow,
    output logic             underflow,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);
    localparam int M   = MAN_W + 1;       // mantissa with hidden bit
    localparam int A   = M + 3;           // aligned mantissa with guard/round/sticky
    localparam int S   = A + 1;           // sum with carry
    localparam int XW  = EXP_W + 2;       // signed working exponent
    localparam int LZW = $clog2(S) + 1;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [XW-1:0] BIAS_X   = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_ILL = 2'b11} op_e;
    typedef enum logic [1:0] {K_SPEC, K_ADD, K_MUL} kind_e;

    logic w_advance;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // ---------------- operand capture rank ----------------
    logic             r_in_valid, r_s1_valid, r_s2_valid;
    logic [W-1:0]     r_in_x, r_in_y;
    op_e              r_in_op;
    logic [TAG_W-1:0] r_in_tag, r_s1_tag, r_s2_tag;

    // Stage valid bits: the whole pipe shifts together only when the output can move.
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_advance) begin
            r_in_valid <= in_valid;
            r_s1_valid <= r_in_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    // Capture operands, op and tag on accept.
    // NOTE: datapath registers have no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_in_x   <= x;
            r_in_y   <= y;
            r_in_op  <= op_e'(op);
            r_in_tag <= in_tag;
        end
    end

    // ---------------- S1: unpack, classify, align / multiply ----------------
    logic             w_xs, w_ys, w_ys_eff, w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_big;
    logic [EXP_W-1:0] w_xe, w_ye, w_big_e, w_diff;
    logic [MAN_W-1:0] w_xf, w_yf;
    logic [A-1:0]     w_big_m, w_small_m, w_shifted;
    logic             w_sticky;

    assign w_xs      = r_in_x[W-1];
    assign w_ys      = r_in_y[W-1];
    assign w_xe      = r_in_x[W-2 -: EXP_W];
    assign w_ye      = r_in_y[W-2 -: EXP_W];
    assign w_xf      = r_in_x[MAN_W-1:0];
    assign w_yf      = r_in_y[MAN_W-1:0];
    assign w_ys_eff  = w_ys ^ (r_in_op == OP_SUB);
    assign w_x_zero  = (w_xe == '0);
    assign w_y_zero  = (w_ye == '0);
    assign w_x_inf   = (w_xe == EXP_ONES);
    assign w_y_inf   = (w_ye == EXP_ONES);
    assign w_x_big   = (r_in_x[W-2:0] >= r_in_y[W-2:0]);
    assign w_big_e   = w_x_big ? w_xe : w_ye;
    assign w_diff    = w_x_big ? (w_xe - w_ye) : (w_ye - w_xe);
    assign w_big_m   = {1'b1, (w_x_big ? w_xf : w_yf), 3'b000};
    assign w_small_m = {1'b1, (w_x_big ? w_yf : w_xf), 3'b000};
    assign w_shifted = w_small_m >> w_diff;
    assign w_sticky  = |(w_small_m & ~({A{1'b1}} << w_diff));

    kind_e                 w1_kind;
    logic                  w1_sign, w1_sub, w1_ovf, w1_ill;
    logic signed [XW-1:0]  w1_exp;
    logic [A-1:0]          w1_ma, w1_mb;
    logic [W-1:0]          w1_res;

    // Special-case resolution and operand preparation for the arithmetic paths.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        w1_kind = K_SPEC;
        w1_sign = 1'b0;
        w1_sub  = 1'b0;
        w1_exp  = '0;
        w1_ma   = '0;
        w1_mb   = '0;
        w1_res  = '0;
        w1_ovf  = 1'b0;
        w1_ill  = 1'b0;
        case (r_in_op)
            OP_ILL: w1_ill = 1'b1;
            OP_MUL: begin
                if (w_x_inf || w_y_inf) begin
                    w1_res = {w_xs ^ w_ys, EXP_ONES, {MAN_W{1'b0}}};
                    w1_ovf = 1'b1;
                end else if (w_x_zero || w_y_zero) begin
                    w1_res = {w_xs ^ w_ys, {(W-1){1'b0}}};
                end else begin
                    w1_kind = K_MUL;
                    w1_sign = w_xs ^ w_ys;
                    w1_exp  = {2'b00, w_xe} + {2'b00, w_ye} - BIAS_X;
                end
            end
            default: begin
                if (w_x_inf) begin
                    w1_res = {w_xs, EXP_ONES, {MAN_W{1'b0}}};
                    w1_ovf = 1'b1;
                end else if (w_y_inf) begin
                    w1_res = {w_ys_eff, EXP_ONES, {MAN_W{1'b0}}};
                    w1_ovf = 1'b1;
                end else if (w_x_zero && w_y_zero) begin
                    w1_res = {w_xs & w_ys_eff, {(W-1){1'b0}}};
                end else if (w_x_zero) begin
                    w1_res = {w_ys_eff, r_in_y[W-2:0]};
                end else if (w_y_zero) begin
                    w1_res = r_in_x;
                end else begin
                    w1_kind = K_ADD;
                    w1_sign = w_x_big ? w_xs : w_ys_eff;
                    w1_sub  = w_xs ^ w_ys_eff;
                    w1_exp  = {2'b00, w_big_e};
                    w1_ma   = w_big_m;
                    w1_mb   = w_shifted | A'(w_sticky);
                end
            end
        endcase
    end

    kind_e                r_s1_kind;
    logic                 r_s1_sign, r_s1_sub, r_s1_ovf, r_s1_ill;
    logic signed [XW-1:0] r_s1_exp;
    logic [A-1:0]         r_s1_ma, r_s1_mb;
    logic [M:0]           r_s1_prod;   // top M+1 bits of the mantissa product
    logic [W-1:0]         r_s1_res;

    // S1 register: prepared operands plus the truncated mantissa product.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_kind <= w1_kind;
            r_s1_sign <= w1_sign;
            r_s1_sub  <= w1_sub;
            r_s1_exp  <= w1_exp;
            r_s1_ma   <= w1_ma;
            r_s1_mb   <= w1_mb;
            r_s1_prod <= (M+1)'(({{M{1'b0}}, 1'b1, w_xf} * {{M{1'b0}}, 1'b1, w_yf}) >> (M - 1));
            r_s1_res  <= w1_res;
            r_s1_ovf  <= w1_ovf;
            r_s1_ill  <= w1_ill;
            r_s1_tag  <= r_in_tag;
        end
    end

    // ---------------- S2: add mantissas and normalise ----------------
    logic [S-1:0]   w_sum, w_norm;
    logic [LZW-1:0] w_lz;

    assign w_sum  = r_s1_sub ? ({1'b0, r_s1_ma} - {1'b0, r_s1_mb})
                             : ({1'b0, r_s1_ma} + {1'b0, r_s1_mb});
    assign w_norm = w_sum << w_lz;

    // Leading-zero count of the sum (highest set bit wins).
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < S; i++) begin
            if (w_sum[i]) w_lz = LZW'(S - 1 - i);
        end
    end

    logic                 w2_special, w2_ovf, w2_ill;
    logic signed [XW-1:0] w2_exp;
    logic [MAN_W-1:0]     w2_frac;
    logic [W-1:0]         w2_res;

    // Normalise the add or multiply result; exact cancellation becomes +0.
    always_comb begin
        w2_special = 1'b1;
        w2_res     = r_s1_res;
        w2_ovf     = r_s1_ovf;
        w2_ill     = r_s1_ill;
        w2_exp     = r_s1_exp;
        w2_frac    = '0;
        case (r_s1_kind)
            K_ADD: begin
                if (w_sum == '0) begin
                    w2_res = '0;
                end else begin
                    w2_special = 1'b0;
                    w2_exp     = r_s1_exp + XW'(1) - XW'(w_lz);
                    w2_frac    = MAN_W'(w_norm >> (S - M));
                end
            end
            K_MUL: begin
                w2_special = 1'b0;
                if (r_s1_prod[M]) begin
                    w2_exp  = r_s1_exp + XW'(1);
                    w2_frac = r_s1_prod[M-1:1];
                end else begin
                    w2_frac = r_s1_prod[M-2:0];
                end
            end
            default: ;
        endcase
    end

    logic                 r_s2_special, r_s2_sign, r_s2_ovf, r_s2_ill;
    logic signed [XW-1:0] r_s2_exp;
    logic [MAN_W-1:0]     r_s2_frac;
    logic [W-1:0]         r_s2_res;

    // S2 register: normalised sign/exponent/fraction or a finished special result.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s2_special <= w2_special;
            r_s2_sign    <= r_s1_sign;
            r_s2_exp     <= w2_exp;
            r_s2_frac    <= w2_frac;
            r_s2_res     <= w2_res;
            r_s2_ovf     <= w2_ovf;
            r_s2_ill     <= w2_ill;
            r_s2_tag     <= r_s1_tag;
        end
    end

    // ---------------- S3: range check and pack ----------------
    // Output registers: saturate/flush out-of-range exponents; bubbles load zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            illegal   <= 1'b0;
            out_tag   <= '0;
        end else if (w_advance) begin
            out_valid <= r_s2_valid;
            out_tag   <= r_s2_valid ? r_s2_tag : '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            illegal   <= 1'b0;
            if (r_s2_valid) begin
                if (r_s2_special) begin
                    result   <= r_s2_res;
                    overflow <= r_s2_ovf;
                    illegal  <= r_s2_ill;
                end else if (r_s2_exp >= EXP_MAX) begin
                    result   <= {r_s2_sign, EXP_ONES, {MAN_W{1'b0}}};
                    overflow <= 1'b1;
                end else if (r_s2_exp <= EXP_ZERO) begin
                    result    <= {r_s2_sign, {(W-1){1'b0}}};
                    underflow <= 1'b1;
                end else begin
                    result <= {r_s2_sign, r_s2_exp[EXP_W-1:0], r_s2_frac};
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_alu_pipe.sv
// Directed bench for fp_alu_pipe with default parameters (binary32).
module tb_fp_alu_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, ILL = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]     x, y, result;
    logic [1:0]       op;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             overflow, underflow, illegal;

    int checks = 0;
    int errors = 0;

    logic [1:0]       bp_op  [4];
    logic [W-1:0]     bp_x   [4];
    logic [W-1:0]     bp_y   [4];
    logic [W-1:0]     bp_res [4];
    logic [TAG_W-1:0] bp_tag [4];

    always #5 clk = ~clk;

    fp_alu_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow),
        .illegal(illegal), .out_tag(out_tag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [31:0] res, input logic ovf,
                              input logic unf, input logic ill, input logic [3:0] tag);
        chk({name, " out_valid"}, out_valid, 1);
        chk({name, " result"}, result, res);
        chk({name, " overflow"}, overflow, ovf);
        chk({name, " underflow"}, underflow, unf);
        chk({name, " illegal"}, illegal, ill);
        chk({name, " out_tag"}, out_tag, tag);
    endtask

    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
        in_valid = 1'b1;
        op       = o;
        x        = a;
        y        = b;
        in_tag   = t;
        tick();
    endtask

    task automatic expect_idle(input string name);
        chk({name, " out_valid"}, out_valid, 0);
        chk({name, " result"}, result, 0);
        chk({name, " flags"}, {overflow, underflow, illegal}, 0);
        chk({name, " out_tag"}, out_tag, 0);
        chk({name, " in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; op = ADD; in_tag = '0;
        tick(); tick();
        expect_idle("reset");
        rst = 1'b0;

        // Latency: 1.5 + 2.0 = 3.5, visible after the third edge.
        send(ADD, 32'h3FC00000, 32'h40000000, 4'd5);
        in_valid = 1'b0;
        chk("lat edge0 out_valid", out_valid, 0);
        tick(); chk("lat edge1 out_valid", out_valid, 0);
        tick(); chk("lat edge2 out_valid", out_valid, 0);
        tick(); expect_out("add 1.5+2.0", 32'h40600000, 0, 0, 0, 4'd5);
        tick(); chk("lat no duplicate", out_valid, 0);

        // Back-to-back sub, mul, exact cancellation.
        send(SUB, 32'h40000000, 32'h3FC00000, 4'd1);
        send(MUL, 32'h3FC00000, 32'h40000000, 4'd2);
        send(ADD, 32'h3F800000, 32'hBF800000, 4'd3);
        in_valid = 1'b0;
        tick(); expect_out("sub 2.0-1.5", 32'h3F000000, 0, 0, 0, 4'd1);
        tick(); expect_out("mul 1.5*2.0", 32'h40400000, 0, 0, 0, 4'd2);
        tick(); expect_out("add 1+(-1)", 32'h00000000, 0, 0, 0, 4'd3);

        // Overflow, underflow, illegal op.
        send(MUL, 32'h7F7FFFFF, 32'h40000000, 4'd4);
        send(MUL, 32'h00800000, 32'h00800000, 4'd5);
        send(ILL, 32'h12345678, 32'h9ABCDEF0, 4'd6);
        in_valid = 1'b0;
        tick(); expect_out("mul ovf", 32'h7F800000, 1, 0, 0, 4'd4);
        tick(); expect_out("mul unf", 32'h00000000, 0, 1, 0, 4'd5);
        tick(); expect_out("illegal op", 32'h00000000, 0, 0, 1, 4'd6);

        // Inf and zero operands in add/sub.
        send(ADD, 32'h7F800000, 32'h3F800000, 4'd7);
        send(ADD, 32'h80000000, 32'h80000000, 4'd8);
        send(SUB, 32'h00000000, 32'h3F800000, 4'd9);
        in_valid = 1'b0;
        tick(); expect_out("inf+1", 32'h7F800000, 1, 0, 0, 4'd7);
        tick(); expect_out("-0+-0", 32'h80000000, 0, 0, 0, 4'd8);
        tick(); expect_out("0-1", 32'hBF800000, 0, 0, 0, 4'd9);

        // Zero and inf operands in mul, opposing infinities in add.
        send(MUL, 32'hC0000000, 32'h00000000, 4'd10);
        send(MUL, 32'h7F800000, 32'h80000000, 4'd11);
        send(ADD, 32'hFF800000, 32'h7F800000, 4'd12);
        in_valid = 1'b0;
        tick(); expect_out("-2*0", 32'h80000000, 0, 0, 0, 4'd10);
        tick(); expect_out("inf*-0", 32'hFF800000, 1, 0, 0, 4'd11);
        tick(); expect_out("-inf+inf", 32'hFF800000, 1, 0, 0, 4'd12);

        // Truncation and add overflow.
        send(ADD, 32'h3F800000, 32'h33800000, 4'd13);
        send(SUB, 32'h3F800000, 32'h33000000, 4'd14);
        send(ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'd15);
        in_valid = 1'b0;
        tick(); expect_out("1+2^-24 trunc", 32'h3F800000, 0, 0, 0, 4'd13);
        tick(); expect_out("1-2^-25 trunc", 32'h3F7FFFFF, 0, 0, 0, 4'd14);
        tick(); expect_out("max+max", 32'h7F800000, 1, 0, 0, 4'd15);

        // Sub underflow to zero, +0 + -0.
        send(SUB, 32'h00800001, 32'h00800000, 4'd0);
        send(ADD, 32'h00000000, 32'h80000000, 4'd1);
        in_valid = 1'b0;
        tick(); tick(); expect_out("sub unf", 32'h00000000, 0, 1, 0, 4'd0);
        tick(); expect_out("+0+-0", 32'h00000000, 0, 0, 0, 4'd1);
        tick();

        // Backpressure: four ops accepted, then the stall holds everything.
        bp_op  = '{ADD, MUL, SUB, ADD};
        bp_x   = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3FC00000};
        bp_y   = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h00000000};
        bp_res = '{32'h40000000, 32'h40800000, 32'hBF800000, 32'h3FC00000};
        bp_tag = '{4'd1, 4'd2, 4'd3, 4'd4};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp in_ready before accept", in_ready, 1);
            send(bp_op[i], bp_x[i], bp_y[i], bp_tag[i]);
        end
        chk("bp in_ready stalled", in_ready, 0);
        expect_out("bp first", bp_res[0], 0, 0, 0, bp_tag[0]);
        send(ILL, 32'h0, 32'h0, 4'd9);
        for (int i = 0; i < 2; i++) begin
            expect_out("bp held", bp_res[0], 0, 0, 0, bp_tag[0]);
            chk("bp held in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_out("bp held last", bp_res[0], 0, 0, 0, bp_tag[0]);
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_out("bp drain", bp_res[i], 0, 0, 0, bp_tag[i]);
        end
        tick(); chk("bp nothing extra", out_valid, 0);

        // Reset with three ops in flight discards them.
        send(ADD, 32'h3F800000, 32'h3F800000, 4'd1);
        send(ADD, 32'h3F800000, 32'h3F800000, 4'd2);
        send(ADD, 32'h3F800000, 32'h3F800000, 4'd3);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle("mid reset");
        send(ADD, 32'h40000000, 32'h40000000, 4'd7);
        in_valid = 1'b0;
        chk("post reset edge0", out_valid, 0);
        tick(); chk("post reset edge1", out_valid, 0);
        tick(); chk("post reset edge2", out_valid, 0);
        tick(); expect_out("post reset op", 32'h40800000, 0, 0, 0, 4'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
